// File: rtl/psmac_pkg.sv
// Shared definitions for the packed-precision MAC controller: precision and
// state encodings, datapath widths and OAFU sign-lane patterns.
package psmac_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned Y_W   = 16;

    typedef enum logic [1:0] {
        PREC_2B  = 2'd0,
        PREC_4B  = 2'd1,
        PREC_8B  = 2'd2,
        PREC_ILL = 2'd3
    } prec_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Per-OAFU-lane sign flags (nibble k = sx(k+1)), indexed by precision code
    localparam logic [15:0] SX_PAT [4] = '{16'hFFFF, 16'hAAAA, 16'h8888, 16'h0000};
    localparam logic [15:0] SY_PAT [4] = '{16'hFFFF, 16'hAAAA, 16'h8888, 16'h0000};

    // Returns {mode1, mode2} for a precision code
    function automatic logic [1:0] prec_modes(input prec_e p);
        logic [1:0] m;
        m = 2'b00;
        case (p)
            PREC_4B: m = 2'b10;
            PREC_8B: m = 2'b11;
            default: m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/psmac_ctrl.sv
// Job controller for a packed-precision OAFU: accepts a job descriptor, streams
// operand words to the OAFU and accumulates its registered results.
module psmac_ctrl
    import psmac_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_prec,
    input  logic               cfg_signed,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_ip,
    input  logic [31:0]        in_wt,
    output logic [31:0]        mac_ip,
    output logic [31:0]        mac_wt,
    output logic [15:0]        mac_sx,
    output logic [15:0]        mac_sy,
    output logic               mac_mode1,
    output logic               mac_mode2,
    input  logic signed [15:0] mac_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic               out_err,
    output logic               busy
);

    state_e             state, state_nx;
    logic [LEN_W-1:0]   remaining;
    logic [ACC_W-1:0]   acc;
    logic               issue_v, y_v, err;
    logic               cfg_hs, in_hs, out_hs, cfg_bad, last_word, final_acc;

    always_comb begin
        cfg_ready = (state == S_IDLE);
        in_ready  = (state == S_RUN) && (remaining != '0);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        cfg_hs    = cfg_valid && cfg_ready;
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        cfg_bad   = (prec_e'(cfg_prec) == PREC_ILL) || (cfg_len == '0);
        last_word = in_hs && (remaining == LEN_W'(1));
        // Final result lands once the last issued word has left the y stage
        final_acc = (state == S_DRAIN) && y_v && !issue_v;
        state_nx  = state;
        case (state)
            S_IDLE:  if (cfg_hs)    state_nx = cfg_bad ? S_DONE : S_RUN;
            S_RUN:   if (last_word) state_nx = S_DRAIN;
            S_DRAIN: if (final_acc) state_nx = S_DONE;
            S_DONE:  if (out_hs)    state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            err       <= 1'b0;
            issue_v   <= 1'b0;
            y_v       <= 1'b0;
            mac_ip    <= '0;
            mac_wt    <= '0;
            mac_sx    <= '0;
            mac_sy    <= '0;
            mac_mode1 <= 1'b0;
            mac_mode2 <= 1'b0;
        end else begin
            issue_v <= in_hs;
            y_v     <= issue_v;
            if (in_hs) begin
                mac_ip    <= in_ip;
                mac_wt    <= in_wt;
                remaining <= remaining - LEN_W'(1);
            end
            if (cfg_hs) begin
                remaining              <= cfg_bad ? '0 : cfg_len;
                acc                    <= '0;
                err                    <= cfg_bad;
                {mac_mode1, mac_mode2} <= prec_modes(prec_e'(cfg_prec));
                mac_sx                 <= cfg_signed ? SX_PAT[cfg_prec] : '0;
                mac_sy                 <= cfg_signed ? SY_PAT[cfg_prec] : '0;
            end else if (y_v) begin
                acc <= acc + {{(ACC_W-Y_W){mac_y[15]}}, mac_y};
            end
        end
    end

    assign out_acc = acc;
    assign out_err = err;

endmodule

// File: tb/tb_psmac_ctrl.sv
// Self-checking bench for psmac_ctrl with a behavioural OAFU stand-in
// (real lane dot-product or stub that echoes mac_ip[15:0]).
module tb_psmac_ctrl;
    import psmac_pkg::*;

    logic        clk, rst;
    logic        cfg_valid, cfg_ready, cfg_signed;
    logic [1:0]  cfg_prec;
    logic [7:0]  cfg_len;
    logic        in_valid, in_ready;
    logic [31:0] in_ip, in_wt, mac_ip, mac_wt;
    logic [15:0] mac_sx, mac_sy;
    logic        mac_mode1, mac_mode2;
    logic [15:0] mac_y;
    logic        out_valid, out_ready, out_err, busy;
    logic [31:0] out_acc;

    psmac_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prec(cfg_prec),
        .cfg_signed(cfg_signed), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_ip(in_ip), .in_wt(in_wt),
        .mac_ip(mac_ip), .mac_wt(mac_wt), .mac_sx(mac_sx), .mac_sy(mac_sy),
        .mac_mode1(mac_mode1), .mac_mode2(mac_mode2), .mac_y(mac_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_err(out_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        stub = 1'b1;
    logic        cur_signed = 1'b0;
    logic [31:0] preload_val = '0;
    logic [31:0] w_ip [256];
    logic [31:0] w_wt [256];

    // Lane-wise dot product of packed operands, truncated to the 16-bit result
    function automatic logic [15:0] dot(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] md, input logic sg);
        int w, va, vb, s;
        w = !md[1] ? 2 : (md[0] ? 8 : 4);
        s = 0;
        for (int k = 0; k < 32 / w; k++) begin
            va = int'((a >> (k * w)) & ((32'd1 << w) - 32'd1));
            vb = int'((b >> (k * w)) & ((32'd1 << w) - 32'd1));
            if (sg && va >= (1 << (w - 1))) va -= (1 << w);
            if (sg && vb >= (1 << (w - 1))) vb -= (1 << w);
            s += va * vb;
        end
        return s[15:0];
    endfunction

    function automatic logic [1:0] md_of(input logic [1:0] p);
        return (p == 2'd0) ? 2'b00 : (p == 2'd1) ? 2'b10 : 2'b11;
    endfunction

    // OAFU stand-in: one-cycle registered result, no reset
    always @(posedge clk)
        mac_y <= stub ? mac_ip[15:0] : dot(mac_ip, mac_wt, {mac_mode1, mac_mode2}, cur_signed);

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic fill(input logic st, input logic [7:0] len, input logic [15:0] y, input logic [31:0] f);
        for (int i = 0; i < 256; i++) begin
            w_ip[i] = st ? {16'($urandom), y} : f;
            w_wt[i] = st ? $urandom : f;
        end
    endtask

    task automatic run_job(input string nm, input logic [1:0] p, input logic sg, input logic [7:0] len,
                           input logic st, input int gap_pct, input int gap_at, input int hold,
                           input logic preload, output logic [31:0] got);
        logic [31:0] exp, snap;
        logic [15:0] y16;
        logic        bad, mode_ok, stable, gapped;
        int          idx, cyc;
        bad = (p == 2'd3) || (len == 8'd0);
        stub = st;
        cur_signed = sg;
        exp = preload ? preload_val : 32'd0;
        cyc = 0;
        while (!cfg_ready && cyc < 100) begin @(negedge clk); cyc++; end
        check({nm, " cfg_ready"}, cfg_ready, 1);
        cfg_valid = 1; cfg_prec = p; cfg_signed = sg; cfg_len = len;
        @(negedge clk);
        cfg_valid = 0; cfg_prec = 2'($urandom); cfg_signed = 1'($urandom); cfg_len = 8'($urandom);
        if (bad) begin
            check({nm, " in_ready"}, in_ready, 0);
            check({nm, " ov_next"}, out_valid, 1);
        end else begin
            if (preload) begin
                force dut.acc = preload_val;
                @(negedge clk);
                release dut.acc;
            end
            idx = 0; cyc = 0; mode_ok = 1; gapped = 0;
            while (idx < int'(len) && cyc < 4000) begin
                if ({mac_mode1, mac_mode2} !== md_of(p) || out_valid ||
                    mac_sx !== (sg ? SX_PAT[p] : 16'h0) || mac_sy !== (sg ? SY_PAT[p] : 16'h0))
                    mode_ok = 0;
                if ((idx == gap_at && !gapped) || $urandom_range(99) < gap_pct) begin
                    in_valid = 0;
                    gapped = (idx == gap_at) ? 1'b1 : gapped;
                end else begin
                    in_valid = 1; in_ip = w_ip[idx]; in_wt = w_wt[idx];
                    if (in_ready) begin
                        y16 = st ? w_ip[idx][15:0] : dot(w_ip[idx], w_wt[idx], md_of(p), sg);
                        exp = exp + {{16{y16[15]}}, y16};
                        idx++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            in_valid = 0; in_ip = $urandom; in_wt = $urandom;
            check({nm, " words"}, idx, {24'd0, len});
            check({nm, " ov_E0"}, out_valid, 0);
            @(negedge clk);
            check({nm, " ov_E1"}, out_valid, 0);
            @(negedge clk);
            check({nm, " ov_E2"}, out_valid, 1);
            check({nm, " modes"}, ({mac_mode1, mac_mode2} === md_of(p)) && mode_ok, 1);
        end
        check({nm, " err"}, out_err, bad);
        check({nm, " acc"}, out_acc, exp);
        got = out_acc;
        snap = out_acc; stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_acc !== snap || !out_valid || cfg_ready || in_ready || out_err !== bad) stable = 0;
        end
        if (hold > 0) check({nm, " hold"}, stable, 1);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check({nm, " idle"}, {out_valid, cfg_ready, busy}, 3'b010);
    endtask

    typedef struct {
        logic [1:0]  p;
        logic        sg;
        logic [7:0]  len;
        logic        st;
        logic [15:0] y;
        logic [31:0] f;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] got;
    int          cnt, cyc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd0, 1'b0, 8'd2,   1'b0, 16'h0000, 32'hFFFF_FFFF, 0, 32'd288};
        tbl[1] = '{2'd3, 1'b0, 8'd4,   1'b1, 16'h1111, 32'h0,         2, 32'd0};
        tbl[2] = '{2'd1, 1'b1, 8'd0,   1'b1, 16'h1111, 32'h0,         0, 32'd0};
        tbl[3] = '{2'd1, 1'b1, 8'd4,   1'b1, 16'hFFFD, 32'h0,         5, 32'hFFFF_FFF4};
        tbl[4] = '{2'd0, 1'b1, 8'd1,   1'b1, 16'h8000, 32'h0,         0, 32'hFFFF_8000};
        tbl[5] = '{2'd2, 1'b0, 8'd255, 1'b1, 16'h7FFF, 32'h0,         0, 32'd8355585};
        tbl[6] = '{2'd1, 1'b0, 8'd255, 1'b1, 16'hFFFF, 32'h0,         1, 32'hFFFF_FF01};
        tbl[7] = '{2'd2, 1'b1, 8'd3,   1'b0, 16'h0000, 32'h0102_0304, 0, 32'd90};
        tbl[8] = '{2'd1, 1'b1, 8'd3,   1'b0, 16'h0000, 32'hFFFF_FFFF, 0, 32'd24};

        rst = 1; cfg_valid = 0; cfg_prec = 0; cfg_signed = 0; cfg_len = 0;
        in_valid = 0; in_ip = 0; in_wt = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("reset_ctl", {cfg_ready, in_ready, out_valid, out_err, busy}, 5'b10000);
        check("reset_acc", out_acc, 0);
        check("reset_mac", {mac_ip | mac_wt, 16'(mac_sx | mac_sy), mac_mode1, mac_mode2}, 0);

        for (int i = 0; i < 9; i++) begin
            fill(tbl[i].st, tbl[i].len, tbl[i].y, tbl[i].f);
            run_job($sformatf("vec%0d", i), tbl[i].p, tbl[i].sg, tbl[i].len, tbl[i].st,
                    20, -1, tbl[i].hold, 1'b0, got);
            check($sformatf("vec%0d table", i), got, tbl[i].exp);
        end

        // Signed 8b with a one-cycle gap before the second word
        w_ip[0] = 32'hABCD_0064; w_ip[1] = 32'h1234_FFCE; w_ip[2] = 32'h5555_0007;
        run_job("gap8s", 2'd2, 1'b1, 8'd3, 1'b1, 0, 1, 0, 1'b0, got);
        check("gap8s table", got, 32'd57);

        // Reset one cycle after the second of four words
        fill(1'b1, 8'd4, 16'h4321, 32'h0);
        stub = 1;
        @(negedge clk);
        cfg_valid = 1; cfg_prec = 2'd2; cfg_signed = 1; cfg_len = 8'd4;
        @(negedge clk);
        cfg_valid = 0;
        cnt = 0; cyc = 0;
        while (cnt < 2 && cyc < 50) begin
            in_valid = 1; in_ip = w_ip[cnt]; in_wt = w_wt[cnt];
            if (in_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        check("rst_words", cnt, 2);
        in_ip = 32'hDEAD_BEEF; rst = 1;
        @(negedge clk);
        rst = 0; in_valid = 0;
        check("rst_ctl", {cfg_ready, in_ready, out_valid, out_err, busy}, 5'b10000);
        check("rst_acc", out_acc, 0);
        check("rst_mac", {mac_ip | mac_wt, 16'(mac_sx | mac_sy), mac_mode1, mac_mode2}, 0);
        repeat (3) @(negedge clk);
        check("rst_quiet", {out_valid, busy, out_acc}, 0);
        fill(1'b1, 8'd1, 16'hFFFF, 32'h0);
        run_job("post_rst", 2'd1, 1'b1, 8'd1, 1'b1, 0, -1, 0, 1'b0, got);
        check("post_rst table", got, 32'hFFFF_FFFF);

        // Accumulator wrap with a preloaded value
        fill(1'b1, 8'd2, 16'h7FFF, 32'h0);
        preload_val = 32'hFFFF_FFF0;
        run_job("wrap", 2'd2, 1'b0, 8'd2, 1'b1, 0, -1, 0, 1'b1, got);
        check("wrap table", got, 32'h0000_FFEE);

        for (int j = 0; j < 40; j++) begin
            logic [7:0] rl;
            rl = 8'($urandom_range(12));
            fill(1'($urandom), rl, 16'($urandom), 32'h0);
            for (int i = 0; i < 256; i++) w_ip[i] = $urandom;
            run_job($sformatf("rnd%0d", j), 2'($urandom), 1'($urandom), rl, 1'($urandom),
                    30, -1, $urandom_range(3), 1'b0, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psmac_ctrl.md
PSMAC_CTRL -- requirements
Module: psmac_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have cfg_valid/cfg_ready, input/output, 1 each: job-descriptor handshake.
REQ-004 SHALL have cfg_prec, input, 2: 0=2b, 1=4b, 2=8b, 3=illegal.
REQ-005 SHALL have cfg_signed, input, 1: 1=signed operands.
REQ-006 SHALL have cfg_len, input, 8: job length in operand words; 0 is illegal.
REQ-007 SHALL have in_valid/in_ready, input/output, 1 each: operand stream handshake.
REQ-008 SHALL have in_ip and in_wt, input, 32 each: packed input and weight word.
REQ-009 SHALL have mac_ip and mac_wt, output, 32 each, registered: OAFU operands.
REQ-010 SHALL have mac_sx and mac_sy, output, 16 each, registered: OAFU sx1..sx4 / sy1..sy4, with sx1 = mac_sx[3:0].
REQ-011 SHALL have mac_mode1 and mac_mode2, output, 1 each, registered: OAFU precision select.
REQ-012 SHALL have mac_y, input, 16, signed: OAFU registered result.
REQ-013 SHALL have out_valid/out_ready, output/input, 1 each: result handshake.
REQ-014 SHALL have out_acc, output, 32, signed: job dot-product result.
REQ-015 SHALL have out_err, output, 1: job rejected as illegal.
REQ-016 SHALL have busy, output, 1: high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 cfg_ready SHALL be 1 only in IDLE; a cfg handshake SHALL latch prec, signed and len, and clear acc.
REQ-019 On a legal cfg: IDLE->RUN; on cfg_prec=3 or cfg_len=0: IDLE->DONE with out_acc=0, out_err=1, and no words consumed.
REQ-020 Mode mapping SHALL be: 2b -> mode1=0, mode2=0; 4b -> 1,0; 8b -> 1,1. Modes SHALL be held constant from cfg accept through DONE.
REQ-021 mac_sx/mac_sy SHALL be all-zero when signed=0, else SX_PAT[prec]/SY_PAT[prec] from the package.
REQ-022 in_ready SHALL be 1 only in RUN while remaining count > 0; each handshake SHALL load mac_ip/mac_wt, set issue-valid, and decrement remaining.
REQ-023 Gaps (in_valid=0) SHALL be allowed; issue-valid SHALL clear on non-handshake cycles.
REQ-024 The 2-stage valid pipeline SHALL track OAFU latency: issue-valid at edge E -> y-valid at E+1 -> acc += sign-extended mac_y at E+2.
REQ-025 mac_y SHALL be accumulated only when y-valid=1; OAFU has no reset and garbage on mac_y SHALL be ignored.
REQ-026 The accumulator SHALL be 32-bit two's complement, wrapping modulo 2^32, with no saturation.
REQ-027 RUN->DRAIN SHALL occur on the handshake that takes remaining to 0.
REQ-028 DRAIN->DONE SHALL occur on the edge performing the final accumulate; out_valid SHALL be high from the second edge after the last word is accepted.
REQ-029 In DONE, out_valid=1 and out_acc/out_err SHALL be stable until out_ready; on the handshake the block SHALL go to IDLE, and a new cfg SHALL be accepted no earlier than the following cycle.

Reset
REQ-030 rst SHALL force IDLE, clear remaining, acc, issue/y-valid, mac_ip, mac_wt, mac_sx, mac_sy, mode1 and mode2 to 0, and set out_valid=0, out_err=0, in_ready=0.
REQ-031 rst mid-job SHALL discard the job; in-flight mac_y SHALL never be accumulated afterward.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-033 The shared package psmac_pkg SHALL hold: prec encoding, state typedef, ACC_W=32, LEN_W=8, SX_PAT/SY_PAT constants.
REQ-034 The block SHALL have no sub-module; OAFU SHALL be instantiated beside psmac_ctrl in the parent; the block SHALL be ~150-250 lines.

Verification
REQ-035 Scenario: 2b unsigned, len=2, ip=wt=0xFFFFFFFF, with real OAFU -> out_acc=288, out_err=0.
REQ-036 Scenario: stub mac_y, 8b signed, len=3, y=100,-50,7, with a 1-cycle in_valid gap -> out_acc=57; mode1=mode2=1 throughout.
REQ-037 Scenario: cfg_prec=3, then separately cfg_len=0 -> out_valid the next cycle, out_acc=0, out_err=1, in_ready never high.
REQ-038 Scenario: out_ready held 0 for 5 cycles in DONE -> out_acc stable, cfg_ready=0; release -> IDLE, next cfg accepted one cycle later.
REQ-039 Scenario: rst asserted 1 cycle after the 2nd of 4 words -> all outputs at reset values; a new len=1 job with stub y=-1 -> out_acc=0xFFFFFFFF.
REQ-040 Scenario: stub y=0x7FFF for 255 words -> out_acc=8355585; wrap check by preloading acc via a hierarchical force -> modulo-2^32 result.
